// File: rtl/writeback.sv
// writeback: MEM/WB pipeline register, write-back mux, halt/dump sequencing and retire counter.
module writeback #(
    parameter int DATA_W = 16,
    parameter int REG_W  = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              Stall,
    input  logic              Flush,
    input  logic              InValid,
    input  logic [DATA_W-1:0] InAluResult,
    input  logic [DATA_W-1:0] InReadData,
    input  logic [DATA_W-1:0] InPcPlus2,
    input  logic [DATA_W-1:0] InImm,
    input  logic [REG_W-1:0]  InWrReg,
    input  logic              InRegWrite,
    input  logic [1:0]        InWbSel,
    input  logic              InHalt,
    output logic [DATA_W-1:0] WrData,
    output logic [REG_W-1:0]  WrReg,
    output logic              WrEn,
    output logic              FwdValid,
    output logic              Halted,
    output logic              DumpReq,
    output logic [15:0]       RetireCount
);
    typedef enum logic [1:0] {RUN, DUMP, HALTED} state_t;
    state_t            state;
    logic              rValid, rRegWrite, rHalt;
    logic [1:0]        rWbSel;
    logic [REG_W-1:0]  rWrReg;
    logic [DATA_W-1:0] rAlu, rRdata, rPcp2, rImm;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= RUN;
            RetireCount <= '0;
            rValid      <= 1'b0;
            rRegWrite   <= 1'b0;
            rHalt       <= 1'b0;
            rWbSel      <= '0;
            rWrReg      <= '0;
            rAlu        <= '0;
            rRdata      <= '0;
            rPcp2       <= '0;
            rImm        <= '0;
        end else if (state == RUN) begin
            if (rValid && rHalt)
                state <= DUMP;
            // a halting instruction always retires on the edge that leaves RUN
            if (rValid && (!Stall || rHalt))
                RetireCount <= RetireCount + 16'd1;
            if (Flush)
                rValid <= 1'b0;
            else if (!Stall) begin
                rValid    <= InValid;
                rRegWrite <= InRegWrite;
                rHalt     <= InHalt;
                rWbSel    <= InWbSel;
                rWrReg    <= InWrReg;
                rAlu      <= InAluResult;
                rRdata    <= InReadData;
                rPcp2     <= InPcPlus2;
                rImm      <= InImm;
            end
        end else
            state <= HALTED;
    end
    assign WrData   = rWbSel == 2'b00 ? rAlu : rWbSel == 2'b01 ? rRdata : rWbSel == 2'b10 ? rPcp2 : rImm;
    assign WrReg    = rWrReg;
    assign WrEn     = rValid & rRegWrite & ~rHalt & (state == RUN);
    assign FwdValid = WrEn;
    assign Halted   = state != RUN;
    assign DumpReq  = state == DUMP;
endmodule

// File: tb/tb_writeback.sv
// tb_writeback: directed scoreboard bench for the writeback stage.
module tb_writeback;
    logic        clk = 1'b0, rst = 1'b1;
    logic        Stall = 1'b0, Flush = 1'b0, InValid = 1'b0, InRegWrite = 1'b0, InHalt = 1'b0;
    logic [15:0] InAluResult = '0, InReadData = 16'hBEEF, InPcPlus2 = 16'h0042, InImm = 16'hFF80;
    logic [2:0]  InWrReg = '0;
    logic [1:0]  InWbSel = '0;
    logic [15:0] WrData, RetireCount;
    logic [2:0]  WrReg;
    logic        WrEn, FwdValid, Halted, DumpReq;

    writeback #(.DATA_W(16), .REG_W(3)) dut (
        .clk(clk), .rst(rst), .Stall(Stall), .Flush(Flush), .InValid(InValid),
        .InAluResult(InAluResult), .InReadData(InReadData), .InPcPlus2(InPcPlus2), .InImm(InImm),
        .InWrReg(InWrReg), .InRegWrite(InRegWrite), .InWbSel(InWbSel), .InHalt(InHalt),
        .WrData(WrData), .WrReg(WrReg), .WrEn(WrEn), .FwdValid(FwdValid),
        .Halted(Halted), .DumpReq(DumpReq), .RetireCount(RetireCount)
    );

    always #5 clk = ~clk;

    typedef struct packed {logic [15:0] d; logic [2:0] r; logic e;} exp_t;
    exp_t        sb[$];
    int          errors = 0, checks = 0;
    logic        mValid = 1'b0;
    logic [15:0] expCount = '0;
    logic [15:0] muxExp [4] = '{16'h1234, 16'hBEEF, 16'h0042, 16'hFF80};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [15:0] d, input logic [2:0] r, input logic e);
        sb.push_back('{d: d, r: r, e: e});
    endtask

    task automatic drive(input logic v, input logic [1:0] sel, input logic [2:0] wr, input logic rw,
                         input logic h, input logic [15:0] a);
        InValid = v; InWbSel = sel; InWrReg = wr; InRegWrite = rw; InHalt = h; InAluResult = a;
    endtask

    // count model: an instruction leaves WB on an unstalled edge
    task automatic tick();
        if (mValid && !Stall) expCount = expCount + 16'd1;
        @(posedge clk);
        #1;
        mValid = Flush ? 1'b0 : Stall ? mValid : InValid;
    endtask

    task automatic popCheck(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL %s observed=empty expected=entry", tag);
        end else begin
            e = sb.pop_front();
            check({tag, ".wren"}, WrEn, e.e);
            check({tag, ".fwd"}, FwdValid, e.e);
            if (e.e) begin
                check({tag, ".data"}, WrData, e.d);
                check({tag, ".reg"}, WrReg, e.r);
            end
        end
    endtask

    task automatic checkIdle(input string tag, input logic [15:0] cnt);
        check({tag, ".wren"}, WrEn, 0);
        check({tag, ".data"}, WrData, 0);
        check({tag, ".reg"}, WrReg, 0);
        check({tag, ".halted"}, Halted, 0);
        check({tag, ".dump"}, DumpReq, 0);
        check({tag, ".count"}, RetireCount, cnt);
    endtask

    task automatic releaseReset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        mValid = 1'b0;
        expCount = '0;
        sb.delete();
    endtask

    initial begin
        #12;
        checkIdle("reset", 16'd0);
        releaseReset();

        for (int i = 0; i < 4; i++) begin
            drive(1'b1, i[1:0], 3'd5, 1'b1, 1'b0, 16'h1234);
            push(muxExp[i], 3'd5, 1'b1);
            tick();
            popCheck($sformatf("mux%0d", i));
            check("mux.count", RetireCount, expCount);
        end
        drive(1'b0, 2'd0, 3'd0, 1'b0, 1'b0, 16'h0);
        tick();
        check("mux.drain.wren", WrEn, 0);
        check("mux.drain.count", RetireCount, 16'd4);

        drive(1'b1, 2'd0, 3'd2, 1'b1, 1'b0, 16'h0A0A);
        push(16'h0A0A, 3'd2, 1'b1);
        tick();
        popCheck("stall.pre");
        Stall = 1'b1;
        drive(1'b1, 2'd0, 3'd3, 1'b1, 1'b0, 16'h5555);
        for (int i = 0; i < 3; i++) begin
            push(16'h0A0A, 3'd2, 1'b1);
            tick();
            popCheck("stall.hold");
            check("stall.hold.count", RetireCount, 16'd4);
        end
        Stall = 1'b0;
        push(16'h5555, 3'd3, 1'b1);
        tick();
        popCheck("stall.release");
        check("stall.release.count", RetireCount, 16'd5);
        Stall = 1'b1;
        Flush = 1'b1;
        drive(1'b1, 2'd0, 3'd4, 1'b1, 1'b0, 16'h6666);
        push(16'h0, 3'd0, 1'b0);
        tick();
        popCheck("stallflush");
        check("stallflush.count", RetireCount, 16'd5);
        Stall = 1'b0;
        Flush = 1'b0;
        drive(1'b0, 2'd0, 3'd0, 1'b0, 1'b0, 16'h0);
        tick();
        check("bubble.wren", WrEn, 0);
        check("bubble.count", RetireCount, expCount);

        drive(1'b1, 2'd1, 3'd6, 1'b1, 1'b0, 16'h1111);
        tick();
        check("prereset.wren", WrEn, 1);
        #2 rst = 1'b1;
        #1 checkIdle("midreset", 16'd0);
        releaseReset();

        Flush = 1'b1;
        drive(1'b1, 2'd0, 3'd7, 1'b1, 1'b1, 16'h0);
        tick();
        Flush = 1'b0;
        drive(1'b0, 2'd0, 3'd0, 1'b0, 1'b0, 16'h0);
        tick();
        tick();
        check("flushhalt.halted", Halted, 0);
        check("flushhalt.dump", DumpReq, 0);

        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 2'd0, i[2:0], 1'b1, 1'b0, 16'h0100 + 16'(i));
            push(16'h0100 + 16'(i), i[2:0], 1'b1);
            tick();
            popCheck("stream");
        end
        drive(1'b1, 2'd0, 3'd7, 1'b1, 1'b1, 16'h7777);
        push(16'h0, 3'd0, 1'b0);
        tick();
        popCheck("halt.inwb");
        check("halt.inwb.halted", Halted, 0);
        check("halt.inwb.dump", DumpReq, 0);
        check("halt.inwb.count", RetireCount, 16'd4);
        drive(1'b1, 2'd0, 3'd1, 1'b1, 1'b0, 16'hAAAA);
        tick();
        check("dump.dump", DumpReq, 1);
        check("dump.halted", Halted, 1);
        check("dump.wren", WrEn, 0);
        check("dump.count", RetireCount, 16'd5);
        for (int i = 0; i < 4; i++) begin
            Flush = i[0];
            Stall = i[1];
            drive(1'b1, i[1:0], 3'd2, 1'b1, 1'b0, 16'hC000 + 16'(i));
            tick();
            check("halted.dump", DumpReq, 0);
            check("halted.halted", Halted, 1);
            check("halted.wren", WrEn, 0);
            check("halted.count", RetireCount, 16'd5);
        end
        Flush = 1'b0;
        Stall = 1'b0;
        #2 rst = 1'b1;
        #1 checkIdle("haltreset", 16'd0);
        releaseReset();

        drive(1'b1, 2'd0, 3'd1, 1'b0, 1'b0, 16'h0);
        for (int k = 0; k < 65536; k++) tick();
        check("wrap.max", RetireCount, 16'hFFFF);
        check("wrap.model", RetireCount, expCount);
        tick();
        check("wrap.zero", RetireCount, 16'h0000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/writeback.md
# writeback

Writeback stage of the five-stage pipelined processor, directly downstream of the memory stage. Holds the MEM/WB pipeline register and selects the register-file write value from ALU result, load data, link address or immediate. Sequences processor halt: once a halting instruction retires it freezes the stage and emits a one-cycle memory-dump request. Counts retired instructions for the performance and verification harness.

## Interface
Parameters:
- DATA_W, 16, datapath width
- REG_W, 3, register-specifier width

Ports:
- clk  in  1  system clock, rising-edge
- rst  in  1  asynchronous, active-high reset
- Stall  in  1  hold MEM/WB register contents
- Flush  in  1  load a bubble into MEM/WB register
- InValid  in  1  memory-stage instruction is valid
- InAluResult  in  DATA_W  ALU result from memory stage
- InReadData  in  DATA_W  load data from memory stage (ReadData)
- InPcPlus2  in  DATA_W  link address
- InImm  in  DATA_W  immediate (LBI/SLBI path)
- InWrReg  in  REG_W  destination register
- InRegWrite  in  1  instruction writes a register
- InWbSel  in  2  00 ALU, 01 load, 10 PC+2, 11 immediate
- InHalt  in  1  instruction is HALT
- WrData  out  DATA_W  register-file write data
- WrReg  out  REG_W  register-file write address
- WrEn  out  1  register-file write enable
- FwdValid  out  1  WB value forwardable (same as WrEn)
- Halted  out  1  processor halted
- DumpReq  out  1  one-cycle createdump pulse
- RetireCount  out  16  retired-instruction count

## Operation
- MEM/WB register fields: valid, alu, rdata, pcp2, imm, wrreg, regwrite, wbsel, halt.
- Update priority per rising edge (state RUN only): Flush -> valid=0, other fields don't-care; else Stall -> hold; else capture all inputs.
- Flush beats Stall when both asserted.
- WrData = mux of registered fields by registered wbsel; combinational from register.
- WrEn = valid & regwrite & (state==RUN); WrReg = registered wrreg.
- FSM states: RUN, DUMP, HALTED.
  - RUN -> DUMP on cycle where registered valid & halt (halting instruction sits in WB).
  - DUMP -> HALTED unconditionally after one cycle.
  - HALTED: absorbing; only rst leaves.
- In DUMP/HALTED: register frozen (ignores Flush/Stall/inputs), WrEn=0.
- DumpReq = (state==DUMP). Halted = (state==DUMP or HALTED).
- HALT instruction with regwrite=1 never writes (WrEn gated in same cycle as transition decision? no — WrEn in RUN is allowed; decoder guarantees regwrite=0 for HALT; stage still gates: WrEn = valid & regwrite & ~halt & RUN).
- RetireCount: +1 on each clock edge where state==RUN and registered valid=1 and Stall=0 (instruction leaves WB); the halting instruction is counted on RUN->DUMP edge. Wraps 0xFFFF -> 0x0000.

## Timing
- Reset (async, immediate): valid=0, all fields 0, state=RUN, RetireCount=0; thus WrEn=0, WrData=0, WrReg=0, Halted=0, DumpReq=0.
- Latency: instruction presented with InValid on edge N produces WrEn/WrData during cycle N..N+1 (one-cycle register latency), writes regfile at edge N+1.
- Stalled instruction keeps WrEn high each held cycle (regfile write idempotent); counted once, on the edge it leaves.
- HALT captured at edge N: DumpReq high for cycle after edge N+1, Halted high from edge N+1 onward.
- rst asserted mid-DUMP or HALTED returns to RUN immediately; DumpReq drops asynchronously.
- Flush of a HALT before capture: no halt occurs.

## Test plan
- Reset: assert rst mid-run with valid data -> all outputs 0 immediately, RetireCount=0.
- Mux: capture alu=0x1234, rdata=0xBEEF, pcp2=0x0042, imm=0xFF80, wrreg=5, regwrite=1, cycle WbSel 00/01/10/11 -> WrData 0x1234/0xBEEF/0x0042/0xFF80, WrReg=5, WrEn=1.
- Stall/flush: Stall=1 for 3 cycles -> outputs held, RetireCount +1 only after release; Stall=Flush=1 -> WrEn=0 next cycle, count unchanged.
- Halt: stream 4 valid instrs then HALT -> RetireCount=5, DumpReq high exactly 1 cycle, Halted stays 1, later inputs ignored, WrEn=0.
- Halt with regwrite=1, wrreg=7 -> WrEn never asserted for it.
- Wrap: preload via 65536 retirements (or force) -> RetireCount 0xFFFF -> 0x0000.
